// File: rtl/lpf_seq_pkg.sv
// Shared types and default sizing for the low-pass bypass sequencer and its crossfade mixer.
package lpf_seq_pkg;

  typedef enum logic [2:0] {
    BYPASS   = 3'd0,
    FILL     = 3'd1,
    FADE_IN  = 3'd2,
    ACTIVE   = 3'd3,
    FADE_OUT = 3'd4
  } state_t;

  localparam int DEF_DWIDTH         = 16;
  localparam int DEF_MAX_DEPTH_LOG2 = 5;
  localparam int DEF_RAMP_LOG2      = 6;
  localparam int DEPTH_SEL_W        = $clog2(DEF_MAX_DEPTH_LOG2 + 1);
  localparam int RAMP_ONE           = 1 << DEF_RAMP_LOG2;

endpackage

// File: rtl/lpf_xfade_mixer.sv
// Registered signed dry/wet crossfade: data_o = dry + ((wet - dry) * k) >>> RAMP_LOG2.
// k = 0 yields dry exactly and k = 2^RAMP_LOG2 yields wet exactly; the result never leaves [dry, wet].
module lpf_xfade_mixer
  import lpf_seq_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int RAMP_LOG2 = DEF_RAMP_LOG2
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     tick_i,
  input  logic signed [DWIDTH-1:0] dry_i,
  input  logic signed [DWIDTH-1:0] wet_i,
  input  logic [RAMP_LOG2:0]       k_i,
  output logic signed [DWIDTH-1:0] data_o
);

  localparam int PW = DWIDTH + RAMP_LOG2 + 2;

  logic signed [DWIDTH:0]   diff;
  logic signed [PW-1:0]     diff_w;
  logic signed [PW-1:0]     k_w;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     scaled;
  logic signed [DWIDTH:0]   sum;
  logic signed [DWIDTH-1:0] data_d, data_q;

  always_comb begin
    diff   = DWIDTH'(wet_i) - DWIDTH'(dry_i);
    diff   = {wet_i[DWIDTH-1], wet_i} - {dry_i[DWIDTH-1], dry_i};
    diff_w = {{(PW-DWIDTH-1){diff[DWIDTH]}}, diff};
    k_w    = {{(PW-RAMP_LOG2-1){1'b0}}, k_i};
    prod   = diff_w * k_w;
    scaled = prod >>> RAMP_LOG2;
    sum    = {dry_i[DWIDTH-1], dry_i} + scaled[DWIDTH:0];
    data_d = tick_i ? sum[DWIDTH-1:0] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/lowpass_bypass_sequencer.sv
// Click-free engage/disengage and depth-change sequencing for a power-of-two moving-average stage.
//   state    | meaning
//   BYPASS   | dry passthrough, filter idle (k = 0)
//   FILL     | filter history refilling at the latched depth (k = 0)
//   FADE_IN  | k ramps up toward full wet
//   ACTIVE   | full wet (k = 2^RAMP_LOG2)
//   FADE_OUT | k ramps down; pend requests a refill at the new depth once dry
module lowpass_bypass_sequencer
  import lpf_seq_pkg::*;
#(
  parameter int DWIDTH         = DEF_DWIDTH,
  parameter int MAX_DEPTH_LOG2 = DEF_MAX_DEPTH_LOG2,
  parameter int RAMP_LOG2      = DEF_RAMP_LOG2
) (
  input  logic                                   clk_i,
  input  logic                                   srst_i,
  input  logic                                   sample_tick_i,
  input  logic                                   enable_i,
  input  logic [$clog2(MAX_DEPTH_LOG2+1)-1:0]    depth_sel_i,
  input  logic signed [DWIDTH-1:0]               dry_i,
  input  logic signed [DWIDTH-1:0]               wet_i,
  output logic [$clog2(MAX_DEPTH_LOG2+1)-1:0]    depth_sel_o,
  output logic signed [DWIDTH-1:0]               data_o,
  output logic                                   busy_o
);

  localparam int DSW = $clog2(MAX_DEPTH_LOG2 + 1);
  localparam int KW  = RAMP_LOG2 + 1;
  localparam int FW  = MAX_DEPTH_LOG2 + 1;
  localparam logic [KW-1:0]  K_ONE     = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [KW-1:0]  K_LAST    = K_ONE - KW'(1);
  localparam logic [DSW-1:0] DEPTH_MAX = DSW'(MAX_DEPTH_LOG2);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            pend_q, pend_d;
  logic [DSW-1:0]  depth_q, depth_d;
  logic            busy_q, busy_d;

  logic [DSW-1:0]  depth_req;
  logic            depth_chg;
  logic [FW-1:0]   fill_last;

  assign depth_req = (depth_sel_i > DEPTH_MAX) ? DEPTH_MAX : depth_sel_i;
  assign depth_chg = (depth_req != depth_q);
  assign fill_last = FW'((32'd1 << depth_q) - 32'd1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fill_d  = fill_q;
    pend_d  = pend_q;
    depth_d = depth_q;
    if (sample_tick_i) begin
      case (state_q)
        BYPASS: begin
          k_d = '0;
          if (enable_i) begin
            depth_d = depth_req;
            fill_d  = '0;
            state_d = FILL;
          end
        end
        FILL: begin
          k_d = '0;
          if (!enable_i) begin
            state_d = BYPASS;
          end else if (depth_chg) begin
            depth_d = depth_req;
            fill_d  = '0;
          end else if (fill_q == fill_last) begin
            state_d = FADE_IN;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        FADE_IN: begin
          // enable drop outranks a depth change, so pend stays clear in that case
          if (!enable_i) begin
            state_d = FADE_OUT;
          end else if (depth_chg) begin
            pend_d  = 1'b1;
            state_d = FADE_OUT;
          end else if (k_q >= K_LAST) begin
            k_d     = K_ONE;
            state_d = ACTIVE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        ACTIVE: begin
          k_d = K_ONE;
          if (!enable_i) begin
            state_d = FADE_OUT;
          end else if (depth_chg) begin
            pend_d  = 1'b1;
            state_d = FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (enable_i && !pend_q && !depth_chg) begin
            state_d = FADE_IN;
          end else begin
            if (enable_i && depth_chg) pend_d = 1'b1;
            if (k_q <= KW'(1)) begin
              k_d = '0;
              if (pend_d && enable_i) begin
                depth_d = depth_req;
                fill_d  = '0;
                state_d = FILL;
              end else begin
                state_d = BYPASS;
              end
              pend_d = 1'b0;
            end else begin
              k_d = k_q - KW'(1);
            end
          end
        end
        default: begin
          state_d = BYPASS;
          k_d     = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == FILL) || (state_d == FADE_IN) || (state_d == FADE_OUT);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= BYPASS;
      k_q     <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      depth_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      depth_q <= depth_d;
      busy_q  <= busy_d;
    end
  end

  // the mix uses k as it stood at this tick, before the FSM update
  lpf_xfade_mixer #(
    .DWIDTH    (DWIDTH),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_mixer (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .tick_i (sample_tick_i),
    .dry_i  (dry_i),
    .wet_i  (wet_i),
    .k_i    (k_q),
    .data_o (data_o)
  );

  assign depth_sel_o = depth_q;
  assign busy_o      = busy_q;

endmodule
